// File: rtl/axi_burst_bridge.sv
// axi_burst_bridge: converts one client read/write request of 1..2^LEN_W
// beats into a single AXI4 INCR burst, streaming beats with backpressure.
// Ports: clk/rst; client req_* (request), wr_* (write beats in),
// rd_* (read beats out), done/err (completion); AXI ar_*/r_* (read),
// aw_*/w_*/b_* (write).
module axi_burst_bridge #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       CADDR_W   = 8,
    parameter int unsigned       LEN_W     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h10000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [CADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic               rd_last,
    input  logic               rd_ready,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  ar_addr,
    output logic [7:0]         ar_len,
    output logic               ar_valid,
    input  logic               ar_ready,
    input  logic [DATA_W-1:0]  r_data,
    input  logic [1:0]         r_resp,
    input  logic               r_last,
    input  logic               r_valid,
    output logic               r_ready,
    output logic [ADDR_W-1:0]  aw_addr,
    output logic [7:0]         aw_len,
    output logic               aw_valid,
    input  logic               aw_ready,
    output logic [DATA_W-1:0]  w_data,
    output logic               w_last,
    output logic               w_valid,
    input  logic               w_ready,
    input  logic [1:0]         b_resp,
    input  logic               b_valid,
    output logic               b_ready
);

    localparam int unsigned SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_DONE
    } state_t;

    state_t              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W:0]      cnt_q;
    logic                err_acc_q;
    logic [ADDR_W-1:0]   ar_addr_q, aw_addr_q;
    logic [7:0]          ar_len_q, aw_len_q;
    logic                ar_valid_q, aw_valid_q;
    logic                done_q, err_q;

    logic                last_beat;
    logic                rd_beat, w_beat;
    logic                r_beat_err, b_err;
    logic [ADDR_W-1:0]   byte_addr;

    assign byte_addr  = BASE_ADDR + (ADDR_W'(req_addr) << SHIFT);
    assign last_beat  = (cnt_q == {1'b0, len_q});
    assign rd_beat    = (state_q == S_RDATA) && r_valid && rd_ready;
    assign w_beat     = (state_q == S_WDATA) && wr_valid && w_ready;
    // A beat is bad on a non-OKAY response or when the slave's RLAST
    // disagrees with our own beat count.
    assign r_beat_err = (r_resp != 2'b00) || (r_last != last_beat);
    assign b_err      = (b_resp != 2'b00);

    assign req_ready = (state_q == S_IDLE);
    assign rd_data   = r_data;
    assign rd_valid  = (state_q == S_RDATA) && r_valid;
    assign r_ready   = (state_q == S_RDATA) && rd_ready;
    assign rd_last   = (state_q == S_RDATA) && last_beat;
    assign w_data    = wr_data;
    assign w_valid   = (state_q == S_WDATA) && wr_valid;
    assign wr_ready  = (state_q == S_WDATA) && w_ready;
    assign w_last    = (state_q == S_WDATA) && last_beat;
    assign b_ready   = (state_q == S_WRESP);

    assign ar_addr   = ar_addr_q;
    assign ar_len    = ar_len_q;
    assign ar_valid  = ar_valid_q;
    assign aw_addr   = aw_addr_q;
    assign aw_len    = aw_len_q;
    assign aw_valid  = aw_valid_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            err_acc_q  <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        len_q <= req_len;
                        if (req_rw) begin
                            ar_addr_q  <= byte_addr;
                            ar_len_q   <= 8'(req_len);
                            ar_valid_q <= 1'b1;
                            state_q    <= S_RADDR;
                        end else begin
                            aw_addr_q  <= byte_addr;
                            aw_len_q   <= 8'(req_len);
                            aw_valid_q <= 1'b1;
                            state_q    <= S_WADDR;
                        end
                    end
                end
                S_RADDR: begin
                    if (ar_ready) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (rd_beat) begin
                        cnt_q     <= cnt_q + 1'b1;
                        err_acc_q <= err_acc_q | r_beat_err;
                        // Our count ends the burst even if RLAST never comes.
                        if (last_beat) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= err_acc_q | r_beat_err;
                        end
                    end
                end
                S_WADDR: begin
                    if (aw_ready) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (w_beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (b_valid) begin
                        err_acc_q <= err_acc_q | b_err;
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_q     <= err_acc_q | b_err;
                    end
                end
                S_DONE: begin
                    cnt_q     <= '0;
                    err_acc_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_bridge.sv
// tb_axi_burst_bridge: randomized bench for axi_burst_bridge with a
// transaction-level client, AXI slave and expected-result model.
module tb_axi_burst_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rw;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        done, err;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        ar_valid, ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last, r_valid, r_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        aw_valid, aw_ready;
    logic [31:0] w_data;
    logic        w_last, w_valid, w_ready;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;

    axi_burst_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .rd_ready(rd_ready), .done(done), .err(err),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid),
        .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready),
        .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid),
        .aw_ready(aw_ready),
        .w_data(w_data), .w_last(w_last), .w_valid(w_valid),
        .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_done_cyc = -10;
    logic [31:0] beat_data [16];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle_inputs(input bit keep_req);
        if (!keep_req) req_valid = 1'b0;
        wr_valid = 1'b0; wr_data = '0;
        rd_ready = 1'b0;
        ar_ready = 1'b0; aw_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
        w_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'b00;
    endtask

    // mode: 0 clean, 1 bad RLAST (read) / bad BRESP (write),
    // 2 bad RRESP on one beat (read) / bad BRESP (write).
    // abort_at != 0 asserts reset once that many read beats were delivered.
    task automatic run_txn(input bit rw, input logic [7:0] addr,
                           input logic [3:0] len, input int mode,
                           input bit hold, input bit b2b, input int abort_at);
        int          cidx, sidx, bad_beat;
        bit          accepted, addr_done, resp_sent, finished;
        logic [31:0] exp_addr;
        exp_addr = 32'h10000 + (32'(addr) << 2);
        for (int i = 0; i < 16; i++) beat_data[i] = $urandom;
        bad_beat = int'($urandom_range(0, 32'(len)));
        cidx = 0; sidx = 0;
        accepted = 0; addr_done = 0; resp_sent = 0; finished = 0;
        for (int t = 0; t < 1000 && !finished; t++) begin
            @(negedge clk);
            cyc++;
            req_valid = !accepted || hold;
            req_rw    = rw;
            req_addr  = addr;
            req_len   = len;
            ar_ready  = ($urandom_range(0, 2) == 0);
            aw_ready  = ($urandom_range(0, 2) == 0);
            rd_ready  = 1'($urandom_range(0, 1));
            r_valid   = rw && addr_done && sidx <= int'(len) &&
                        ($urandom_range(0, 3) != 0);
            r_data    = beat_data[sidx % 16];
            r_last    = (sidx == int'(len)) ^ (mode == 1 && sidx == 0);
            r_resp    = (mode == 2 && sidx == bad_beat) ? 2'b10 : 2'b00;
            wr_valid  = !rw && accepted && cidx <= int'(len) &&
                        ($urandom_range(0, 3) != 0);
            wr_data   = beat_data[cidx % 16];
            w_ready   = 1'($urandom_range(0, 1));
            b_valid   = !rw && sidx > int'(len) && !resp_sent &&
                        1'($urandom_range(0, 1));
            b_resp    = (mode != 0) ? 2'b10 : 2'b00;
            if (abort_at != 0 && cidx == abort_at) begin
                r_valid  = 1'b1;
                rd_ready = 1'b1;
                rst = 1'b1;
                #1;
                check("abort_rd_valid", 64'(rd_valid), 64'd0);
                check("abort_r_ready", 64'(r_ready), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_ar_valid", 64'(ar_valid), 64'd0);
                check("abort_req_ready", 64'(req_ready), 64'd1);
                idle_inputs(1'b0);
                repeat (2) begin
                    @(negedge clk);
                    cyc++;
                    check("abort_no_done", 64'(done), 64'd0);
                end
                rst = 1'b0;
                return;
            end
            #1;
            if (t == 0) check("done_one_cycle", 64'(done), 64'd0);
            if (req_valid && req_ready && !accepted) begin
                accepted = 1;
                if (b2b) check("b2b_accept_cyc", 64'(cyc),
                               64'(last_done_cyc + 1));
            end
            if (rw) begin
                if (addr_done) begin
                    check("ar_single", 64'(ar_valid), 64'd0);
                end else if (ar_valid && ar_ready) begin
                    check("ar_addr", 64'(ar_addr), 64'(exp_addr));
                    check("ar_len", 64'(ar_len), 64'(len));
                    addr_done = 1;
                end
                if (r_valid && r_ready) sidx++;
                if (rd_valid && rd_ready) begin
                    if (cidx > int'(len)) begin
                        check("rd_extra_beat", 64'(cidx), 64'(len));
                    end else begin
                        check("rd_data", 64'(rd_data), 64'(beat_data[cidx]));
                        check("rd_last", 64'(rd_last),
                              64'(cidx == int'(len)));
                    end
                    cidx++;
                end
            end else begin
                if (addr_done) begin
                    check("aw_single", 64'(aw_valid), 64'd0);
                end else if (aw_valid && aw_ready) begin
                    check("aw_addr", 64'(aw_addr), 64'(exp_addr));
                    check("aw_len", 64'(aw_len), 64'(len));
                    addr_done = 1;
                end
                if (w_valid && w_ready) begin
                    if (sidx > int'(len)) begin
                        check("w_extra_beat", 64'(sidx), 64'(len));
                    end else begin
                        check("w_data", 64'(w_data), 64'(beat_data[sidx]));
                        check("w_last", 64'(w_last),
                              64'(sidx == int'(len)));
                    end
                    sidx++;
                end
                if (wr_valid && wr_ready) cidx++;
                if (b_valid && b_ready) resp_sent = 1;
            end
            if (done) begin
                check("err", 64'(err), 64'(mode != 0));
                check("beats", 64'(rw ? cidx : sidx), 64'(int'(len) + 1));
                check("req_ready_busy", 64'(req_ready), 64'd0);
                last_done_cyc = cyc;
                finished = 1;
            end
        end
        check("timeout", 64'(finished), 64'd1);
        idle_inputs(hold);
    endtask

    initial begin
        bit prev_hold;
        bit hold;
        rst = 1'b1;
        req_rw = 1'b0; req_addr = '0; req_len = '0;
        idle_inputs(1'b0);
        repeat (3) @(negedge clk);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_ar_addr", 64'(ar_addr), 64'd0);
        check("rst_aw_addr", 64'(aw_addr), 64'd0);
        check("rst_ar_len", 64'(ar_len), 64'd0);
        check("rst_aw_len", 64'(aw_len), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        rst = 1'b0;

        run_txn(1'b1, 8'h05, 4'd0, 0, 1'b0, 1'b0, 0);
        run_txn(1'b1, 8'hFF, 4'd3, 0, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'(($urandom)), 4'd15, 0, 1'b0, 1'b0, 0);
        run_txn(1'b1, 8'h40, 4'd1, 1, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'h41, 4'd2, 2, 1'b0, 1'b0, 0);
        run_txn(1'b1, 8'h22, 4'd3, 0, 1'b0, 1'b0, 2);
        run_txn(1'b1, 8'h23, 4'd3, 0, 1'b0, 1'b0, 0);
        run_txn(1'b0, 8'h10, 4'd2, 0, 1'b1, 1'b0, 0);
        run_txn(1'b1, 8'h20, 4'd1, 0, 1'b0, 1'b1, 0);

        prev_hold = 1'b0;
        for (int k = 0; k < 30; k++) begin
            hold = ($urandom_range(0, 3) == 0);
            run_txn(1'($urandom_range(0, 1)), 8'($urandom),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ?
                        int'($urandom_range(1, 2)) : 0,
                    hold, prev_hold, 0);
            prev_hold = hold;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_burst_bridge.md
Name: axi_burst_bridge

Overview:
- Parametrised successor to the single-beat DRAM bridge: converts one client request (read or write, 1..2^LEN_W beats) into an AXI4 INCR burst on the DRAM port.
- Streams write data in and read data out with valid/ready backpressure.
- Checks RLAST/WLAST consistency and response codes, and reports completion plus an error flag per transaction.
- Sits between the core controller and the DRAM AXI slave.

Parameters:
- DATA_W, 32, data beat width in bits; power of two, minimum 8.
- ADDR_W, 32, AXI address width.
- CADDR_W, 8, client word-address width.
- LEN_W, 4, burst length field width; a burst is req_len+1 beats, maximum 16.
- BASE_ADDR, 32'h10000, byte offset added to every DRAM address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  bridge can accept a request (IDLE only).
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  CADDR_W  start word address.
- req_len  in  LEN_W  beats minus 1.
- wr_data  in  DATA_W  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- rd_data  out  DATA_W  read beat data.
- rd_valid  out  1  read beat valid.
- rd_last  out  1  final read beat.
- rd_ready  in  1  client accepts read beat.
- done  out  1  one-cycle completion pulse.
- err  out  1  error status, valid with done.
- ar_addr/ar_len/ar_valid  out  ADDR_W/8/1  AXI read address channel.
- ar_ready  in  1  AXI read address ready.
- r_data/r_resp/r_last/r_valid  in  DATA_W/2/1/1  AXI read data channel.
- r_ready  out  1  AXI read data ready.
- aw_addr/aw_len/aw_valid  out  ADDR_W/8/1  AXI write address channel.
- aw_ready  in  1  AXI write address ready.
- w_data/w_last/w_valid  out  DATA_W/1/1  AXI write data channel.
- w_ready  in  1  AXI write data ready.
- b_resp/b_valid  in  2/1  AXI write response channel.
- b_ready  out  1  AXI write response ready.

Behaviour:
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
- Reset (async, any state): state = IDLE. All registered outputs 0: ar_addr, ar_len, ar_valid, aw_addr, aw_len, aw_valid, done, err. Beat counter = 0, error accumulator = 0. A reset mid-burst abandons the transaction with no done pulse.
- req_ready = (state==IDLE). On req_valid&&req_ready the bridge:
  - latches addr, len and rw;
  - computes the byte address = BASE_ADDR + (req_addr << log2(DATA_W/8)), zero-extended to ADDR_W;
  - zero-extends the length field to 8 bits;
  - moves to RADDR (read) or WADDR (write).
- RADDR: ar_valid=1 and ar_addr/ar_len held stable until ar_ready. ar_valid drops the cycle after the handshake; go to RDATA. WADDR/aw_* behave identically; go to WDATA.
- RDATA: combinational pass-through.
  - rd_data=r_data; rd_valid=r_valid; r_ready=rd_ready.
  - rd_last=(cnt==len).
  - On each r_valid&&r_ready: cnt++. OR into the error accumulator if r_resp!=0 or r_last!=(cnt==len).
  - On the beat where cnt==len: go to DONE, even if r_last is missing (counter governs).
- WDATA: combinational pass-through.
  - w_data=wr_data; w_valid=wr_valid; wr_ready=w_ready; w_last=(cnt==len).
  - On each handshake: cnt++. After the beat where cnt==len, go to WRESP.
- WRESP: b_ready=1. On b_valid, OR (b_resp!=0) into the error accumulator and go to DONE.
- DONE: done=1 and err=accumulator for exactly one cycle, then clear cnt and the accumulator and return to IDLE. Next req_ready is asserted the cycle after done.
- All stream/AXI ready/valid outputs are 0 outside their own state.
- Beat counter is LEN_W+1 bits wide; it never wraps within a legal burst.
- Client requests while busy are not accepted (req_ready=0); the client holds them.

Test Plan:
- Single read: req_rw=1, addr=8'h05, len=0; ar_ready after 2 cycles; r_data=32'hDEADBEEF with r_last=1 → ar_addr=32'h10014, ar_len=0, rd_data=32'hDEADBEEF with rd_last=1, done pulse, err=0.
- Read burst of 4 with rd_ready toggling every other cycle: addr=8'hFF → ar_addr=32'h103FC, ar_len=3, exactly 4 beats delivered in order, rd_last on beat 4 only, no beat lost, err=0.
- Write burst of 16 (len=15) with w_ready stalls and wr_valid gaps → aw_len=15, 16 w handshakes, w_last only on beat 16, b_resp=0 → done, err=0.
- Error cases:
  - Read of 2 beats with r_last asserted on beat 1 → two beats passed, done, err=1.
  - Write with b_resp=2'b10 → done, err=1.
- Reset mid-burst: assert rst during RDATA beat 2 of 4 → all outputs 0 immediately, no done; a new request after release completes normally.
- Back-to-back: req_valid held high across two requests → second accepted the cycle after the first done; the ar_valid/aw_valid handshakes are not merged.
